// File: rtl/merge8_serial_unload.sv
// Serial unloader for the merge network: captures the sorted vector on start and streams
// it out one element per valid/ready transfer, ascending or descending.
module merge8_serial_unload #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned N     = 4,
  localparam int unsigned Cnt  = 2 * N,
  localparam int unsigned IdxW = (Cnt > 1) ? $clog2(Cnt) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_desc,
  input  logic [Cnt*WIDTH-1:0]   i_inc,
  output logic [WIDTH-1:0]       o_out_data,
  output logic [IdxW-1:0]        o_out_idx,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic                   o_out_last,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Cnt - 1);
  localparam logic [IdxW-1:0] One     = IdxW'(1);

  state_e                      r_state, w_state_d;
  logic [Cnt-1:0][WIDTH-1:0]   r_shadow, w_shadow_d;
  logic [IdxW-1:0]             r_cnt, w_cnt_d;
  logic                        r_desc, w_desc_d;
  logic [IdxW-1:0]             w_term;
  logic                        w_at_term;

  // Terminal index depends on the direction latched at capture.
  assign w_term    = r_desc ? '0 : LastIdx;
  assign w_at_term = (r_cnt == w_term);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= StIdle;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_desc   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_shadow <= w_shadow_d;
      r_cnt    <= w_cnt_d;
      r_desc   <= w_desc_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shadow_d  = r_shadow;
    w_cnt_d     = r_cnt;
    w_desc_d    = r_desc;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_shadow_d = i_inc;
          w_desc_d   = i_desc;
          w_cnt_d    = i_desc ? LastIdx : '0;
          w_state_d  = StSend;
        end
      end
      StSend: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_last  = w_at_term;
        if (i_out_ready) begin
          if (w_at_term) begin
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_desc ? (r_cnt - One) : (r_cnt + One);
          end
        end
      end
      StDone: begin
        o_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Data and index come straight from registers, so they hold during stalls and clear on reset.
  assign o_out_data = r_shadow[r_cnt];
  assign o_out_idx  = r_cnt;

endmodule

// File: tb/tb_merge8_serial_unload.sv
// Scoreboard bench: stimulus pushes the expected element stream per burst, a negedge monitor
// compares every presented element and the busy/done handshake.
module tb_merge8_serial_unload;
  localparam int unsigned W = 3;
  localparam int unsigned N = 4;
  localparam int unsigned C = 2 * N;

  typedef struct {
    int unsigned idx;
    int unsigned data;
    int unsigned last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             desc;
  logic [C*W-1:0]   inc;
  logic [W-1:0]     out_data;
  logic [2:0]       out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;
  logic             done;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   expect_done = 0;

  merge8_serial_unload #(.WIDTH(W), .N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_desc      (desc),
    .i_inc       (inc),
    .o_out_data  (out_data),
    .o_out_idx   (out_idx),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT should be presenting data exactly while the model has elements pending.
  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", out_valid, (q.size() > 0) ? 1 : 0);
      chk("busy", busy, (q.size() > 0) ? 1 : 0);
      chk("done", done, expect_done ? 1 : 0);
      expect_done = 0;
      if (out_valid && q.size() > 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_idx", out_idx, q[0].idx);
        chk("out_last", out_last, q[0].last);
        if (out_ready) begin
          if (q[0].last != 0) expect_done = 1;
          void'(q.pop_front());
        end
      end
    end
  end

  function automatic logic [C*W-1:0] pack(input int unsigned e[C]);
    logic [C*W-1:0] v;
    for (int k = 0; k < C; k++) v[k*W +: W] = W'(e[k]);
    return v;
  endfunction

  function automatic logic [C*W-1:0] rand_sorted();
    logic [W-1:0]   s[$];
    logic [C*W-1:0] v;
    for (int k = 0; k < C; k++) s.push_back(W'($urandom_range(0, 7)));
    s.sort();
    for (int k = 0; k < C; k++) v[k*W +: W] = s[k];
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // mode: 0 ready high, 1 random ready, 2 stall cycles 2-4, 3 start/inc churn mid-burst,
  // 4 reset after the third transfer. Called at posedge+1 with the DUT idle.
  task automatic run_burst(input logic [C*W-1:0] vec, input logic d, input int mode);
    int k;
    start = 1'b1;
    inc   = vec;
    desc  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < int'(C); j++) begin
      exp_t e;
      int unsigned r;
      r      = d ? (C - 1 - j) : j;
      e.idx  = r;
      e.data = int'(vec[r*W +: W]);
      e.last = (j == int'(C) - 1) ? 1 : 0;
      q.push_back(e);
    end
    k = 0;
    while (q.size() > 0) begin
      if (k > 200) begin
        chk("burst_timeout", q.size(), 0);
        q.delete();
        break;
      end
      case (mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: out_ready = (k >= 2 && k <= 4) ? 1'b0 : 1'b1;
        3: begin
          out_ready = 1'b1;
          start     = (k == 3) ? 1'b1 : 1'b0;
          if (k == 3) begin
            inc  = '1;
            desc = ~d;
          end
        end
        4: out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
      if (mode == 4 && k == 3) begin
        rst = 1'b0;
        #1;
        q.delete();
        expect_done = 0;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst_hold");
        rst = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    desc      = 1'b0;
    inc       = '0;
    out_ready = 1'b1;
    #3;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_burst(pack('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 0);
    run_burst(pack('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b1, 0);
    run_burst(pack('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 2);
    run_burst(pack('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 3);
    repeat (4) @(posedge clk);
    #1;
    run_burst(pack('{0, 1, 2, 3, 4, 5, 6, 7}), 1'b0, 4);
    run_burst(pack('{1, 2, 2, 4, 4, 5, 6, 6}), 1'b1, 0);
    run_burst(pack('{0, 0, 3, 3, 5, 7, 7, 7}), 1'b0, 0);
    run_burst(pack('{0, 0, 3, 3, 5, 7, 7, 7}), 1'b1, 1);
    for (int b = 0; b < 24; b++) begin
      run_burst(rand_sorted(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 0 : 1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/merge8_serial_unload.md
Name: merge8_serial_unload

Overview:
- Output-side reader for the 8-element odd-even merge network.
- Captures the packed 2*n-element sorted vector on a start strobe, then streams it out one element per transfer over a valid/ready interface, in ascending or descending order.
- Sits between the merge stage and the downstream consumer; it frees the merge network as soon as the vector is captured.

Parameters:
- WIDTH, 3, bit width of one element.
- n, 4, elements per input half; the unit streams 2*n elements.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  capture request; sampled only in IDLE.
- desc  input  1  order select, sampled with start: 0 = element 0 first (ascending), 1 = element 2n-1 first (descending).
- inc  input  2*n*WIDTH  packed sorted vector; element k at bits [(k+1)*WIDTH-1 : k*WIDTH], element 0 smallest.
- out_data  output  WIDTH  current element.
- out_idx  output  clog2(2*n)  rank of the current element within the captured vector (0..2n-1, always the storage index).
- out_valid  output  1  out_data/out_idx/out_last valid.
- out_ready  input  1  consumer accepts the element when high together with out_valid.
- out_last  output  1  high with the final element of the burst.
- busy  output  1  high from the capture cycle through the final transfer.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst low, asynchronous) forces: state IDLE, shadow register 0, counter 0, out_data 0, out_idx 0, out_valid 0, out_last 0, busy 0, done 0.
- Reset asserted mid-burst aborts the burst immediately. No done pulse is produced for an aborted burst.
- States are IDLE, SEND and DONE.
- IDLE:
  - out_valid = 0, busy = 0.
  - When start = 1 at a clock edge: latch inc into the shadow register and latch desc. Load the counter with 0 (asc) or 2n-1 (desc). Go to SEND.
- SEND:
  - out_valid = 1, busy = 1. out_data is the shadow element at the counter value, and out_idx equals the counter value. This is a registered state, so the first element appears the cycle after start (latency 1).
  - A transfer occurs when out_valid and out_ready are both high.
  - On a transfer that is not the last, the counter steps +1 (asc) or -1 (desc).
  - On the last transfer (counter = 2n-1 asc, 0 desc), go to DONE.
  - Without a transfer (out_ready = 0), out_data, out_idx and out_last hold stable. The shadow register never changes during SEND.
- out_last = 1 exactly when in SEND and the counter equals the terminal index for the latched direction.
- DONE:
  - done = 1 for this one cycle, out_valid = 0, busy = 0.
  - Return to IDLE unconditionally. start in DONE is ignored; it must be re-asserted in IDLE.
- Starts and input changes outside IDLE:
  - start asserted in SEND or DONE is ignored; it is not queued.
  - Changes on inc or desc outside the IDLE capture edge have no effect.
- Back-to-back bursts: minimum spacing is 2n transfers + DONE + IDLE. The next capture can occur 2 cycles after the last transfer.
- Counter arithmetic:
  - The counter is clog2(2*n) bits and never wraps; the terminal checks prevent it.
  - For 2*n that is not a power of two, counter values at or above 2n are unreachable.
- Throughput: with out_ready held high, one element per cycle, 2n+2 cycles from start to the return to IDLE.

Test Plan:
- Asc stream: WIDTH=3, n=4, inc elements {0,1,2,3,4,5,6,7}, desc=0, out_ready=1 -> out_data 0..7 on 8 consecutive cycles starting 1 cycle after start; out_last only with 7; done pulses the next cycle.
- Desc stream: same inc, desc=1 -> out_data 7,6,...,0 with out_idx 7..0; out_last with element 0 (out_idx 0).
- Backpressure: asc, out_ready low on cycles 2-4 of the burst -> out_data holds 2 with out_idx 2 through the stall; the sequence stays 0..7 with no drops or duplicates; done arrives 3 cycles later than in the no-stall case.
- Ignored start and input change: pulse start and change inc to all 7s during SEND -> the current burst still emits the originally captured values; no second burst follows.
- Reset mid-burst: drive rst low after the 3rd transfer -> all outputs go to 0 asynchronously with no done pulse; after release the unit sits in IDLE and a fresh start streams correctly.
- Duplicates/extremes: inc {0,0,3,3,5,7,7,7} -> emitted in order with duplicates preserved; the max value 7 is carried at full WIDTH.
